exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage ARM pipeline; consumes the ID/EX register outputs.
//  Forwards operands, builds Val2 (immediate/shift/mem offset), runs the ALU and computes the branch target.
//  Holds the NZCV status register; its C bit feeds the ID/EX carry input upstream.
//  All outputs are combinational except status, which is registered.
// PARAMETERS
//  WIDTH  32  datapath width; only 32 is supported.
// PORTS
//  clk            in   1   clock, rising edge.
//  rst            in   1   synchronous, active-high reset.
//  exe_cmd        in   4   ALU op from ID/EX.
//  mem_r_en       in   1   load in EXE.
//  mem_w_en       in   1   store in EXE.
//  s_update       in   1   S bit: write status this cycle.
//  pc             in   32  PC+4 of the instruction.
//  val_rn         in   32  Rn value from ID/EX.
//  val_rm         in   32  Rm value from ID/EX.
//  imm            in   1   I bit: shift_operand is rotate-immediate.
//  shift_operand  in   12  ARM shifter operand field.
//  signed_imm24   in   24  branch offset, in words.
//  carry_in       in   1   C flag captured at ID.
//  sel_src1       in   2   Rn forward select.
//  sel_src2       in   2   Rm forward select.
//  fwd_mem        in   32  ALU result held in EX/MEM.
//  fwd_wb         in   32  WB write-back value.
//  alu_result     out  32  ALU result, or memory address for LDR/STR.
//  st_val         out  32  forwarded Rm, the store data.
//  branch_addr    out  32  pc + sext(signed_imm24)<<2.
//  status         out  4   registered {N,Z,C,V}.
// BEHAVIOUR
//  - Forwarding select codes: 00 = register, 01 = fwd_mem, 10 = fwd_wb, 11 = treated as 00.
//    The forwarded Rm drives both Val2 and st_val.
//  - Val2 priority order:
//    1. mem_r_en|mem_w_en: {20'b0, shift_operand}.
//    2. imm: {24'b0, so[7:0]} rotated right by 2*so[11:8] (rotate 0 = no rotation).
//    3. Otherwise Rm shifted by so[11:7] using so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
//       A shift amount of 0 passes Rm unchanged for every shift type.
//  - ALU ops (exe_cmd):
//    - 0001 MOV: Val2.
//    - 1001 MVN: ~Val2.
//    - 0010 ADD: A+Val2.
//    - 0011 ADC: A+Val2+carry_in.
//    - 0100 SUB/CMP: A-Val2.
//    - 0101 SBC: A-Val2-!carry_in.
//    - 0110 AND/TST.
//    - 0111 ORR.
//    - 1000 EOR.
//    - Any other code: result 0.
//    - Loads and stores force ADD.
//  - Flags:
//    - N = res[31]; Z = (res == 0).
//    - Arithmetic: C = bit 32 of the 33-bit sum; for SUB/SBC, C = NOT borrow. V = signed overflow.
//    - Logic/MOV/MVN: C and V keep the current status[1:0].
//  - Latency: alu_result, st_val and branch_addr are valid in the same cycle as the inputs.
//    Status is written on the next rising edge when s_update=1.
//  - Reset: status <= 4'b0000. rst wins over a simultaneous s_update.
//    A reset mid-operation discards the pending status write.
//  - Flushed or bubbled instructions arrive with s_update=0 (ID/EX clears it), so status holds.
//  - branch_addr is computed in 32 bits; wrap-around past 0xFFFFFFFF or below 0 is modulo 2^32.
// STRUCTURE
//  - arm_pkg: exe_cmd codes, shift types (LSL/LSR/ASR/ROR), forward-select codes, status bit indices.
//  - Sub-module val2_gen: the combinational Val2 builder (rotate/shift/mem offset), unit-tested alone.
//  - The ALU and status register stay in exe_stage.
// TESTING
//  1. ADD 0x7FFFFFFF+0x1, s_update=1
//     -> alu_result 0x80000000; status=1001 (N,V) after the edge.
//  2. SUB 5-5, S=1
//     -> result 0; status=0110 (Z,C).
//     Then SBC 5-3 with carry_in=0 -> result 1.
//  3. MOV, imm=1, so=0x4FF
//     -> Val2 0xFF000000; status unchanged when s_update=0.
//  4. Register shifts with Rm=0x00000001:
//     - ROR #1 -> 0x80000000.
//     - ASR #4 on Rm=0x80000000 -> 0xF8000000.
//     - LSL #0 -> Rm unchanged.
//  5. Forwarding with ADD:
//     - sel_src1=01, fwd_mem=0x10, sel_src2=10, fwd_wb=0x20 -> 0x30.
//     - sel=11 -> register values are used.
//     - STR with so=0x004: address = Rn+4, st_val = forwarded Rm.
//  6. Branch target and reset:
//     - pc=0x100, imm24=0xFFFFFE -> branch_addr 0xF8.
//     - rst=1 together with s_update=1 and ADD 0xFFFFFFFF+1 -> status 0000.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shifter types,
// forwarding selects and NZCV bit positions.
package arm_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  // The reserved select code falls back to the register-file value.
  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] rf_val,
                                               input logic [WIDTH-1:0] mem_val,
                                               input logic [WIDTH-1:0] wb_val);
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return rf_val;
    endcase
  endfunction

endpackage

// File: rtl/val2_gen.sv
// Builds the second ALU operand: memory offset, rotated immediate or shifted Rm.
module val2_gen
  import arm_pkg::*;
(
  input  logic             mem_en,
  input  logic             imm,
  input  logic [11:0]      shift_operand,
  input  logic [WIDTH-1:0] val_rm,
  output logic [WIDTH-1:0] val2
);

  logic [4:0]       rot_amt;
  logic [4:0]       sh_amt;
  logic [WIDTH-1:0] imm32;
  logic [WIDTH-1:0] imm_rot;
  logic [WIDTH-1:0] rm_shift;

  assign rot_amt = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];
  assign imm32   = {24'd0, shift_operand[7:0]};
  // A left shift by the full width yields zero, so rotate 0 degenerates cleanly.
  assign imm_rot = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));

  always_comb begin
    rm_shift = val_rm;
    if (sh_amt != 5'd0) begin
      case (shift_e'(shift_operand[6:5]))
        SH_LSL:  rm_shift = val_rm << sh_amt;
        SH_LSR:  rm_shift = val_rm >> sh_amt;
        SH_ASR:  rm_shift = $signed(val_rm) >>> sh_amt;
        default: rm_shift = (val_rm >> sh_amt) | (val_rm << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end

  always_comb begin
    if (mem_en)   val2 = {20'd0, shift_operand};
    else if (imm) val2 = imm_rot;
    else          val2 = rm_shift;
  end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: operand forwarding, Val2, ALU, branch target and the
// registered NZCV status.
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       exe_cmd,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             s_update,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  input  logic             imm,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      signed_imm24,
  input  logic             carry_in,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [WIDTH-1:0] fwd_wb,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] st_val,
  output logic [WIDTH-1:0] branch_addr,
  output logic [3:0]       status
);

  logic             mem_en;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_rm;
  logic [WIDTH-1:0] val2;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c_flag;
  logic             v_flag;
  logic [3:0]       status_q;
  logic [3:0]       status_d;

  assign mem_en = mem_r_en | mem_w_en;
  assign cmd    = mem_en ? CMD_ADD : exe_cmd;
  assign op_a   = fwd_mux(sel_src1, val_rn, fwd_mem, fwd_wb);
  assign op_rm  = fwd_mux(sel_src2, val_rm, fwd_mem, fwd_wb);

  val2_gen u_val2_gen (
    .mem_en        (mem_en),
    .imm           (imm),
    .shift_operand (shift_operand),
    .val_rm        (op_rm),
    .val2          (val2)
  );

  // Subtraction is A + ~B + carry so bit WIDTH is directly the ARM "not borrow".
  always_comb begin
    sum    = '0;
    res    = '0;
    c_flag = status_q[ST_C];
    v_flag = status_q[ST_V];
    case (cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, op_a} + {1'b0, val2} + {{WIDTH{1'b0}}, (cmd == CMD_ADC) & carry_in};
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (op_a[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, op_a} + {1'b0, ~val2} + {{WIDTH{1'b0}}, (cmd == CMD_SUB) | carry_in};
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (op_a[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      CMD_AND: res = op_a & val2;
      CMD_ORR: res = op_a | val2;
      CMD_EOR: res = op_a ^ val2;
      default: res = '0;
    endcase
  end

  assign status_d = s_update ? {res[WIDTH-1], (res == '0), c_flag, v_flag} : status_q;

  always_ff @(posedge clk) begin
    if (rst) status_q <= 4'b0000;
    else     status_q <= status_d;
  end

  assign alu_result  = res;
  assign st_val      = op_rm;
  assign branch_addr = pc + {{(WIDTH-26){signed_imm24[23]}}, signed_imm24, 2'b00};
  assign status      = status_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exe_cmd;
  logic        mem_r_en, mem_w_en, s_update, imm, carry_in;
  logic [31:0] pc, val_rn, val_rm, fwd_mem, fwd_wb;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm24;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] alu_result, st_val, branch_addr;
  logic [3:0]  status;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_txn = 0;
  logic [3:0]  exp_status;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .exe_cmd       (exe_cmd),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .s_update      (s_update),
    .pc            (pc),
    .val_rn        (val_rn),
    .val_rm        (val_rm),
    .imm           (imm),
    .shift_operand (shift_operand),
    .signed_imm24  (signed_imm24),
    .carry_in      (carry_in),
    .sel_src1      (sel_src1),
    .sel_src2      (sel_src2),
    .fwd_mem       (fwd_mem),
    .fwd_wb        (fwd_wb),
    .alu_result    (alu_result),
    .st_val        (st_val),
    .branch_addr   (branch_addr),
    .status        (status)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'd1) return m;
    if (sel == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
    logic [31:0] y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
    return y;
  endfunction

  function automatic logic [31:0] m_val2(input logic mem, input logic im,
                                         input logic [11:0] so, input logic [31:0] rm);
    int amt;
    if (mem) return {20'd0, so};
    if (im) return m_ror({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    amt = int'(so[11:7]);
    if (amt == 0) return rm;
    case (so[6:5])
      2'd0:    return rm << amt;
      2'd1:    return rm >> amt;
      2'd2:    return $signed(rm) >>> amt;
      default: return m_ror(rm, amt);
    endcase
  endfunction

  // Flags from plain wide integer arithmetic rather than bit tricks.
  task automatic m_alu(output logic [31:0] res, output logic c, output logic v);
    logic [31:0] a, b;
    logic [3:0]  op;
    longint ua, ub, sa, sb, full, sres, cin;
    a   = m_fwd(sel_src1, val_rn, fwd_mem, fwd_wb);
    b   = m_val2(mem_r_en | mem_w_en, imm, shift_operand,
                 m_fwd(sel_src2, val_rm, fwd_mem, fwd_wb));
    op  = (mem_r_en | mem_w_en) ? 4'd2 : exe_cmd;
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cin = longint'(carry_in);
    c   = exp_status[1];
    v   = exp_status[0];
    full = 0;
    sres = 0;
    res  = 32'd0;
    case (op)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3: begin
        if (op == 4'd2) cin = 0;
        full = ua + ub + cin;
        sres = sa + sb + cin;
        res  = full[31:0];
        c    = (full >= 64'sh1_0000_0000);
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin  = (op == 4'd4) ? 0 : 1 - cin;  // borrow-in
        full = ua - ub - cin;
        sres = sa - sb - cin;
        res  = full[31:0];
        c    = (ua >= ub + cin);
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: res = 32'd0;
    endcase
  endtask

  // Inputs are set at the falling edge; combinational outputs checked before the
  // rising edge, status checked just after it.
  task automatic step();
    logic [31:0] eres, ebr;
    logic        ec, ev;
    longint      off;
    #1;
    m_alu(eres, ec, ev);
    off = longint'($signed(signed_imm24));
    off = longint'({32'd0, pc}) + off * 4;
    ebr = off[31:0];
    check_val("alu_result", alu_result, eres);
    check_val("st_val", st_val, m_fwd(sel_src2, val_rm, fwd_mem, fwd_wb));
    check_val("branch_addr", branch_addr, ebr);
    @(posedge clk);
    #1;
    if (rst)           exp_status = 4'b0000;
    else if (s_update) exp_status = {eres[31], eres == 32'd0, ec, ev};
    check_val("status", {28'd0, status}, {28'd0, exp_status});
    $display("txn %0d cmd=%h rst=%b s=%b res=%h st=%h br=%h nzcv=%b",
             n_txn, exe_cmd, rst, s_update, alu_result, st_val, branch_addr, status);
    n_txn++;
    @(negedge clk);
  endtask

  task automatic defaults();
    rst = 0; exe_cmd = 4'd2; mem_r_en = 0; mem_w_en = 0; s_update = 0;
    pc = 32'd0; val_rn = 32'd0; val_rm = 32'd0; imm = 0; shift_operand = 12'd0;
    signed_imm24 = 24'd0; carry_in = 0; sel_src1 = 2'd0; sel_src2 = 2'd0;
    fwd_mem = 32'd0; fwd_wb = 32'd0;
  endtask

  initial begin
    defaults();
    exp_status = 4'b0000;
    rst = 1;
    @(negedge clk);
    step();
    check_val("reset_status", {28'd0, status}, 32'd0);
    rst = 0;

    // ADD overflow into sign bit
    exe_cmd = 4'd2; s_update = 1; val_rn = 32'h7FFF_FFFF; val_rm = 32'd1;
    step();
    check_val("add_ovf_res", alu_result, 32'h8000_0000);
    check_val("add_ovf_nzcv", {28'd0, status}, 32'h9);

    // SUB equal operands, then SBC with carry clear
    exe_cmd = 4'd4; val_rn = 32'd5; val_rm = 32'd5;
    step();
    check_val("sub_zero_nzcv", {28'd0, status}, 32'h6);
    exe_cmd = 4'd5; val_rm = 32'd3; carry_in = 0; s_update = 0;
    step();
    check_val("sbc_res", alu_result, 32'd1);

    // MOV rotated immediate, no status write
    exe_cmd = 4'd1; imm = 1; shift_operand = 12'h4FF;
    step();
    check_val("mov_imm", alu_result, 32'hFF00_0000);
    check_val("mov_hold", {28'd0, status}, 32'h6);
    imm = 0;

    // register shifts
    val_rm = 32'd1; shift_operand = 12'h0E0;
    step();
    check_val("ror1", alu_result, 32'h8000_0000);
    val_rm = 32'h8000_0000; shift_operand = 12'h240;
    step();
    check_val("asr4", alu_result, 32'hF800_0000);
    val_rm = 32'h1234_5678; shift_operand = 12'h000;
    step();
    check_val("lsl0", alu_result, 32'h1234_5678);

    // forwarding
    exe_cmd = 4'd2; val_rn = 32'd1; val_rm = 32'd2;
    sel_src1 = 2'd1; fwd_mem = 32'h10; sel_src2 = 2'd2; fwd_wb = 32'h20;
    step();
    check_val("fwd_add", alu_result, 32'h30);
    sel_src1 = 2'd3; sel_src2 = 2'd3;
    step();
    check_val("fwd_rsv", alu_result, 32'd3);
    mem_w_en = 1; exe_cmd = 4'd6; shift_operand = 12'h004;
    val_rn = 32'h1000; sel_src1 = 2'd0; sel_src2 = 2'd1; fwd_mem = 32'hCAFE;
    step();
    check_val("str_addr", alu_result, 32'h1004);
    check_val("str_data", st_val, 32'hCAFE);
    mem_w_en = 0; sel_src2 = 2'd0; shift_operand = 12'd0;

    // branch target and reset priority
    pc = 32'h100; signed_imm24 = 24'hFFFFFE;
    step();
    check_val("branch_back", branch_addr, 32'hF8);
    rst = 1; s_update = 1; exe_cmd = 4'd2; val_rn = 32'hFFFF_FFFF; val_rm = 32'd1;
    step();
    check_val("rst_wins", {28'd0, status}, 32'd0);
    rst = 0;

    for (int i = 0; i < 300; i++) begin
      rst           = ($urandom_range(0, 24) == 0);
      exe_cmd       = 4'($urandom_range(0, 15));
      mem_r_en      = ($urandom_range(0, 7) == 0);
      mem_w_en      = ($urandom_range(0, 7) == 0);
      s_update      = 1'($urandom);
      imm           = 1'($urandom);
      carry_in      = 1'($urandom);
      sel_src1      = 2'($urandom);
      sel_src2      = 2'($urandom);
      shift_operand = 12'($urandom);
      signed_imm24  = 24'($urandom);
      pc            = $urandom;
      val_rn        = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      val_rm        = ($urandom_range(0, 3) == 0) ? val_rn : $urandom;
      fwd_mem       = $urandom;
      fwd_wb        = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
